// File: rtl/vga_pkg.sv
// Shared definitions for the VGA-side SDRAM arbiter: FSM state encoding and burst geometry.
package vga_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_REQ   = 2'd1;
  localparam logic [1:0] ARB_BURST = 2'd2;

  localparam int unsigned SDRAM_BURST_BYTES = 32;

  typedef enum logic [1:0] {
    StIdle  = ARB_IDLE,
    StReq   = ARB_REQ,
    StBurst = ARB_BURST
  } arb_state_e;

endpackage

// File: rtl/vga_sdram_arbiter_if.sv
// Requester-side and SDRAM-side signal bundle of the arbiter; master is the arbiter's view.
interface vga_sdram_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_req;
  logic [32*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]    req_ack;
  logic [31:0]           req_data;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_complete;
  logic                  sdram_req;
  logic [31:0]           sdram_addr;
  logic                  sdram_ack;
  logic [31:0]           sdram_data;
  logic                  sdram_valid;
  logic                  sdram_complete;
  logic [NUM_REQ-1:0]    grant;

  modport master (
    input  req_req, req_addr, sdram_ack, sdram_data, sdram_valid, sdram_complete,
    output req_ack, req_data, req_valid, req_complete, sdram_req, sdram_addr, grant
  );

  modport slave (
    output req_req, req_addr, sdram_ack, sdram_data, sdram_valid, sdram_complete,
    input  req_ack, req_data, req_valid, req_complete, sdram_req, sdram_addr, grant
  );
endinterface

// File: rtl/vga_rr_pick.sv
// Combinational round-robin picker over ports 1..NUM_REQ-1, starting at ptr_i and wrapping to 1.
module vga_rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:1] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               found_o
);

  int unsigned p;

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    p        = 0;
    for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
      // ptr_i is never 0, so ptr_i-1+k stays non-negative
      p = (32'(ptr_i) - 32'd1 + k) % (NUM_REQ - 1) + 32'd1;
      if (!found_o && req_i[IdxW'(p)]) begin
        winner_o[IdxW'(p)] = 1'b1;
        found_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_sdram_arbiter.sv
// Shares the SDRAM burst-read port: port 0 has bounded priority, ports 1..N-1 rotate round-robin.
module vga_sdram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned MAX_PRI_RUN = 4
) (
  input logic                clock,
  input logic                reset,
  vga_sdram_arbiter_if.master bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               sdram_req_q, sdram_req_d;
  logic [31:0]        sdram_addr_q, sdram_addr_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]         pri_run_q, pri_run_d;

  logic [NUM_REQ-1:0] rr_win, win_oh;
  logic               rr_found;
  logic               others_req, win_zero;
  logic [31:0]        win_addr;
  logic [IdxW-1:0]    rr_next;

  vga_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req_i   (bus.req_req[NUM_REQ-1:1]),
    .ptr_i   (rr_ptr_q),
    .winner_o(rr_win),
    .found_o (rr_found)
  );

  assign others_req = |bus.req_req[NUM_REQ-1:1];
  // Port 0 yields once it has won MAX_PRI_RUN times in a row against a waiting port
  assign win_zero   = bus.req_req[0] &&
                      !((pri_run_q == 4'(MAX_PRI_RUN)) && others_req);

  always_comb begin
    win_oh   = win_zero ? NUM_REQ'(1) : (rr_found ? rr_win : '0);
    win_addr = '0;
    rr_next  = IdxW'(1);
    for (int unsigned p = 0; p < NUM_REQ; p++) begin
      if (win_oh[p]) begin
        win_addr = bus.req_addr[32*p +: 32];
        rr_next  = (p == NUM_REQ - 1) ? IdxW'(1) : IdxW'(p + 1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    rr_ptr_d     = rr_ptr_q;
    pri_run_d    = pri_run_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req_req) begin
          grant_d      = win_oh;
          sdram_addr_d = win_addr;
          sdram_req_d  = 1'b1;
          state_d      = StReq;
          if (win_zero) begin
            if (!others_req)              pri_run_d = 4'd0;
            else if (pri_run_q != 4'hF)   pri_run_d = pri_run_q + 4'd1;
          end else begin
            pri_run_d = 4'd0;
            rr_ptr_d  = rr_next;
          end
        end
      end
      StReq: begin
        if (bus.sdram_ack) begin
          sdram_req_d = 1'b0;
          if (bus.sdram_complete) begin
            grant_d = '0;
            state_d = StIdle;
          end else begin
            state_d = StBurst;
          end
        end
      end
      StBurst: begin
        if (bus.sdram_complete) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        grant_d     = '0;
        sdram_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      rr_ptr_q     <= IdxW'(1);
      pri_run_q    <= 4'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      rr_ptr_q     <= rr_ptr_d;
      pri_run_q    <= pri_run_d;
    end
  end

  // grant_q is zero in IDLE, so the masks alone keep routed outputs quiet there
  assign bus.req_ack      = grant_q & {NUM_REQ{bus.sdram_ack}};
  assign bus.req_valid    = grant_q & {NUM_REQ{bus.sdram_valid}};
  assign bus.req_complete = grant_q & {NUM_REQ{bus.sdram_complete}};
  assign bus.req_data     = bus.sdram_data;
  assign bus.sdram_req    = sdram_req_q;
  assign bus.sdram_addr   = sdram_addr_q;
  assign bus.grant        = grant_q;

endmodule
